// File: rtl/display_mux_n.sv
// display_mux_n: N-digit multiplexed 7-segment driver with shadowed display
// data, per-digit enable/dp masks, 16-level PWM brightness and selectable
// segment/anode polarity.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// (the last digit is always shown). Undefined by default.
module display_mux_n #(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned DIV_WIDTH       = 14,
  parameter int unsigned SEG_ACTIVE_HIGH = 1,
  parameter int unsigned AN_ACTIVE_HIGH  = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [3:0]              brightness,
  input  logic                    load,
  output logic [7:0]              segmentos_out,
  output logic [NUM_DIGITS-1:0]   anodos_out,
  output logic                    frame_tick
);

  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  // XOR masks that turn active-high internal values into pin polarity
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_HIGH != 0) ? 8'h00 : 8'hFF;
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_HIGH != 0) ? {NUM_DIGITS{1'b0}} : {NUM_DIGITS{1'b1}};

  logic [DIV_WIDTH-1:0]  cnt;
  logic [IDX_W-1:0]      idx;
  logic                  load_pending;
  logic [DATA_W-1:0]     shadow_data;
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [NUM_DIGITS-1:0] shadow_en;

  logic                  dwell_end_c;
  logic                  wrap_c;
  logic                  pwm_on_c;
  logic                  digit_on_c;
  logic [3:0]            nibble_c;
  logic                  dp_c;
  logic                  en_c;
  logic                  blank_c;
  logic [6:0]            glyph_c;
  logic [7:0]            seg_c;
  logic [NUM_DIGITS-1:0] an_c;
`ifdef LEADING_ZERO_BLANK_EN
  logic                  lead_zero_c;
`endif

  // Hex digit to common-cathode {g,f,e,d,c,b,a} pattern
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0:    hex_to_seg = 7'h3F;
      4'h1:    hex_to_seg = 7'h06;
      4'h2:    hex_to_seg = 7'h5B;
      4'h3:    hex_to_seg = 7'h4F;
      4'h4:    hex_to_seg = 7'h66;
      4'h5:    hex_to_seg = 7'h6D;
      4'h6:    hex_to_seg = 7'h7D;
      4'h7:    hex_to_seg = 7'h07;
      4'h8:    hex_to_seg = 7'h7F;
      4'h9:    hex_to_seg = 7'h6F;
      4'hA:    hex_to_seg = 7'h77;
      4'hB:    hex_to_seg = 7'h7C;
      4'hC:    hex_to_seg = 7'h39;
      4'hD:    hex_to_seg = 7'h5E;
      4'hE:    hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  // End of dwell and end of frame (last digit finishing its dwell)
  always_comb begin
    dwell_end_c = &cnt;
    wrap_c      = dwell_end_c && (idx == LAST_IDX);
  end

  // Pick the shadow nibble, dp and enable of the current digit
  always_comb begin
    nibble_c = 4'h0;
    dp_c     = 1'b0;
    en_c     = 1'b0;
    blank_c  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    lead_zero_c = 1'b1;
`endif
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
`ifdef LEADING_ZERO_BLANK_EN
      lead_zero_c = lead_zero_c & (shadow_data[int'(DATA_W) - 1 - 4*i -: 4] == 4'h0);
`endif
      if (idx == IDX_W'(i)) begin
        nibble_c = shadow_data[int'(DATA_W) - 1 - 4*i -: 4];
        dp_c     = shadow_dp[i];
        en_c     = shadow_en[i];
`ifdef LEADING_ZERO_BLANK_EN
        blank_c  = lead_zero_c && (i != int'(NUM_DIGITS) - 1);
`endif
      end
    end
  end

  // PWM gate and decoded output values; segments go dark with the anode
  always_comb begin
    pwm_on_c   = (cnt[DIV_WIDTH-1 -: 4] <= brightness);
    digit_on_c = pwm_on_c && en_c && !blank_c;
    glyph_c    = hex_to_seg(nibble_c);
    seg_c      = 8'h00;
    an_c       = '0;
    if (digit_on_c) begin
      seg_c = {dp_c, glyph_c};
      an_c  = NUM_DIGITS'(1) << idx;
    end
  end

  // Free-running dwell counter and digit index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + DIV_WIDTH'(1);
      if (dwell_end_c) begin
        idx <= wrap_c ? '0 : idx + IDX_W'(1);
      end
    end
  end

  // Load request latch and frame-boundary shadow update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_pending <= 1'b0;
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_en    <= '0;
    end else if (wrap_c) begin
      load_pending <= 1'b0;
      if (load_pending || load) begin
        shadow_data <= data_in;
        shadow_dp   <= dp_mask;
        shadow_en   <= digit_en;
      end
    end else if (load) begin
      load_pending <= 1'b1;
    end
  end

  // Output pins, polarity applied at the register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      segmentos_out <= SEG_OFF;
      anodos_out    <= AN_OFF;
      frame_tick    <= 1'b0;
    end else begin
      segmentos_out <= seg_c ^ SEG_OFF;
      anodos_out    <= an_c ^ AN_OFF;
      frame_tick    <= wrap_c;
    end
  end

endmodule

// File: tb/tb_display_mux_n.sv
// tb_display_mux_n: directed bench for display_mux_n with 4 digits and a
// 16-cycle dwell (64-cycle frame). Honours LEADING_ZERO_BLANK_EN if defined.
module tb_display_mux_n;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  digit_en = 4'h0;
  logic [3:0]  brightness = 4'h0;
  logic        load = 1'b0;
  logic [7:0]  segmentos_out;
  logic [3:0]  anodos_out;
  logic        frame_tick;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  display_mux_n #(
    .NUM_DIGITS(4),
    .DIV_WIDTH(4),
    .SEG_ACTIVE_HIGH(1),
    .AN_ACTIVE_HIGH(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .data_in(data_in),
    .dp_mask(dp_mask),
    .digit_en(digit_en),
    .brightness(brightness),
    .load(load),
    .segmentos_out(segmentos_out),
    .anodos_out(anodos_out),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sampling happens on the falling edge
  task automatic tick();
    @(negedge clk);
    cyc++;
    load = 1'b0;
  endtask

  // Asynchronous reset asserted between edges, then released on a falling edge
  task automatic do_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_an", 32'(anodos_out), 32'h0);
    check("rst_seg", 32'(segmentos_out), 32'h00);
    check("rst_ft", 32'(frame_tick), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  // Cycles with a dark display; frame_tick expected every 64 cycles
  task automatic run_dark(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      check($sformatf("dark_an@%0d", cyc), 32'(anodos_out), 32'h0);
      check($sformatf("dark_seg@%0d", cyc), 32'(segmentos_out), 32'h00);
      check($sformatf("dark_ft@%0d", cyc), 32'(frame_tick), 32'((cyc % 64) == 0));
    end
  endtask

  // One full frame starting at a frame boundary: digit d owns 16 cycles,
  // lit for the first bright+1 of them when enabled
  task automatic check_frame(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3,
                             input logic [3:0] en, input int bright);
    logic [7:0] segs [4];
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    segs = '{s0, s1, s2, s3};
    for (int j = 1; j <= 64; j++) begin
      int d;
      int ph;
      tick();
      d  = (j - 1) / 16;
      ph = (j - 1) % 16;
      if (en[d] && (ph <= bright)) begin
        exp_an  = 4'(1 << d);
        exp_seg = segs[d];
      end else begin
        exp_an  = 4'h0;
        exp_seg = 8'h00;
      end
      check($sformatf("an@%0d", cyc), 32'(anodos_out), 32'(exp_an));
      check($sformatf("seg@%0d", cyc), 32'(segmentos_out), 32'(exp_seg));
      check($sformatf("ft@%0d", cyc), 32'(frame_tick), 32'(j == 64));
    end
  endtask

  initial begin
    // T1: reset state and free-running frame ticks with no load
    do_reset();
    run_dark(200);

    // T2: load at cycle 5 becomes visible only after the first frame_tick
    do_reset();
    data_in    = 16'h12AF;
    dp_mask    = 4'b0010;
    digit_en   = 4'hF;
    brightness = 4'd15;
    run_dark(5);
    load = 1'b1;
    run_dark(59);
    check_frame(8'h06, 8'hDB, 8'h77, 8'h71, 4'hF, 15);

    // T3: two loads in one frame collapse; only the later data appears
    do_reset();
    data_in = 16'h1111;
    dp_mask = 4'h0;
    run_dark(10);
    load = 1'b1;
    run_dark(10);
    data_in = 16'h2222;
    load = 1'b1;
    run_dark(44);
    check_frame(8'h5B, 8'h5B, 8'h5B, 8'h5B, 4'hF, 15);

    // T4: brightness 3 gives 4 of 16 cycles, brightness 0 gives 1 of 16
    brightness = 4'd3;
    check_frame(8'h5B, 8'h5B, 8'h5B, 8'h5B, 4'hF, 3);
    brightness = 4'd0;
    check_frame(8'h5B, 8'h5B, 8'h5B, 8'h5B, 4'hF, 0);

    // T5: digit 2 disabled for three frames; old data shown until the boundary
    brightness = 4'd15;
    data_in  = 16'h12AF;
    dp_mask  = 4'b0010;
    digit_en = 4'b1011;
    load = 1'b1;
    check_frame(8'h5B, 8'h5B, 8'h5B, 8'h5B, 4'hF, 15);
    for (int f = 0; f < 3; f++) begin
      check_frame(8'h06, 8'hDB, 8'h77, 8'h71, 4'b1011, 15);
    end

    // T6: leading zeros, with and without blanking
    data_in  = 16'h0005;
    dp_mask  = 4'b0001;
    digit_en = 4'hF;
    load = 1'b1;
    check_frame(8'h06, 8'hDB, 8'h77, 8'h71, 4'b1011, 15);
`ifdef LEADING_ZERO_BLANK_EN
    check_frame(8'h00, 8'h00, 8'h00, 8'h6D, 4'b1000, 15);
`else
    check_frame(8'hBF, 8'h3F, 8'h3F, 8'h6D, 4'hF, 15);
`endif
    data_in = 16'h0000;
    dp_mask = 4'h0;
    load = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    check_frame(8'h00, 8'h00, 8'h00, 8'h6D, 4'b1000, 15);
    check_frame(8'h00, 8'h00, 8'h00, 8'h3F, 4'b1000, 15);
`else
    check_frame(8'hBF, 8'h3F, 8'h3F, 8'h6D, 4'hF, 15);
    check_frame(8'h3F, 8'h3F, 8'h3F, 8'h3F, 4'hF, 15);
`endif

    // T7: reset mid-frame while lit clears everything, shadow included
    data_in = 16'h8888;
    load = 1'b1;
    check_frame(8'h3F, 8'h3F, 8'h3F, 8'h3F, 4'hF, 15);
    check_frame(8'h7F, 8'h7F, 8'h7F, 8'h7F, 4'hF, 15);
    for (int k = 0; k < 3; k++) tick();
    check("lit_before_rst", 32'(anodos_out), 32'h1);
    do_reset();
    run_dark(70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
